// File: rtl/vm1_qbus_arb.sv
// vm1_qbus_arb - Qbus DMA bus arbiter for the vm1 core.
//
// Generalises the single DMR/DMGO/SACK chain to NCH radial channels. One
// requester is chosen by fixed priority (RR=0, channel 0 highest) or
// round-robin (RR=1). New CPU bus cycles are held off, a one-hot grant is
// issued once the current CPU cycle completes, SACK ownership is tracked,
// and a grant that is never acknowledged is aborted after TMO cycles.
//
// Ports:
//   pin_clk   in   processor clock, rising edge
//   pin_dclo  in   asynchronous active-high reset
//   cpu_sync  in   CPU bus cycle in progress
//   dmr       in   [NCH] per-channel DMA request (level)
//   sack      in   [NCH] per-channel selection acknowledge (level)
//   cpu_hold  out  CPU must not start a new bus cycle
//   dmg       out  [NCH] per-channel grant, one-hot or zero
//   bus_own   out  a DMA master holds the bus (SACK held)
//   own_id    out  index of the latched winner, valid while cpu_hold=1
//   tmo       out  one-cycle pulse when a grant times out
module vm1_qbus_arb #(
    parameter int NCH = 4,
    parameter int TMO = 64,
    parameter int RR  = 0
) (
    input  logic                   pin_clk,
    input  logic                   pin_dclo,
    input  logic                   cpu_sync,
    input  logic [NCH-1:0]         dmr,
    input  logic [NCH-1:0]         sack,
    output logic                   cpu_hold,
    output logic [NCH-1:0]         dmg,
    output logic                   bus_own,
    output logic [$clog2(NCH)-1:0] own_id,
    output logic                   tmo
);

    localparam int IDW = $clog2(NCH);
    localparam int CW  = $clog2(TMO) + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_GRANT = 3'd2,
        S_OWN   = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t          state_q;
    logic            cpu_hold_q;
    logic [NCH-1:0]  dmg_q;
    logic            bus_own_q;
    logic [IDW-1:0]  own_id_q;
    logic            tmo_q;
    logic [CW-1:0]   cnt_q;
    logic [IDW-1:0]  ptr_q;

    logic [IDW-1:0]  base_d;
    logic [IDW-1:0]  win_d;
    logic [IDW-1:0]  nxt_id_d;
    logic [NCH-1:0]  grant_d;

    // First requester at or above base, wrapping modulo NCH. The request
    // vector is rotated so the search always starts at bit 0.
    function automatic logic [IDW-1:0] pick(input logic [NCH-1:0] req,
                                            input logic [IDW-1:0] base);
        logic [2*NCH-1:0] dbl;
        logic [NCH-1:0]   rot;
        logic [IDW-1:0]   off;
        logic             found;
        logic [IDW:0]     sum;
        dbl   = {req, req} >> base;
        rot   = dbl[NCH-1:0];
        off   = '0;
        found = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (!found && rot[i]) begin
                off   = IDW'(i);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= (IDW+1)'(NCH)) begin
            pick = IDW'(sum - (IDW+1)'(NCH));
        end else begin
            pick = sum[IDW-1:0];
        end
    endfunction

    // Winner selection, pointer successor and one-hot grant for the owner.
    always_comb begin
        base_d = (RR != 0) ? ptr_q : '0;
        win_d  = pick(dmr, base_d);
        if (own_id_q == IDW'(NCH - 1)) begin
            nxt_id_d = '0;
        end else begin
            nxt_id_d = own_id_q + IDW'(1);
        end
        grant_d = NCH'(1) << own_id_q;
    end

    // Arbitration FSM with registered outputs.
    always_ff @(posedge pin_clk or posedge pin_dclo) begin
        if (pin_dclo) begin
            state_q    <= S_IDLE;
            cpu_hold_q <= 1'b0;
            dmg_q      <= '0;
            bus_own_q  <= 1'b0;
            own_id_q   <= '0;
            tmo_q      <= 1'b0;
            cnt_q      <= '0;
            ptr_q      <= '0;
        end else begin
            tmo_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (|dmr) begin
                        own_id_q   <= win_d;
                        cpu_hold_q <= 1'b1;
                        state_q    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A CPU cycle already under way finishes before the grant.
                    if (!dmr[own_id_q]) begin
                        cpu_hold_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end else if (!cpu_sync) begin
                        dmg_q   <= grant_d;
                        cnt_q   <= '0;
                        state_q <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (cnt_q != {CW{1'b1}}) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                    // sack beats withdrawal beats timeout.
                    if (sack[own_id_q]) begin
                        dmg_q     <= '0;
                        bus_own_q <= 1'b1;
                        state_q   <= S_OWN;
                    end else if (!dmr[own_id_q]) begin
                        dmg_q   <= '0;
                        ptr_q   <= nxt_id_d;
                        state_q <= S_GAP;
                    end else if (cnt_q == CW'(TMO - 1)) begin
                        dmg_q   <= '0;
                        tmo_q   <= 1'b1;
                        ptr_q   <= nxt_id_d;
                        state_q <= S_GAP;
                    end
                end
                S_OWN: begin
                    if (!sack[own_id_q]) begin
                        bus_own_q <= 1'b0;
                        ptr_q     <= nxt_id_d;
                        state_q   <= S_GAP;
                    end
                end
                S_GAP: begin
                    cpu_hold_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: begin
                    state_q    <= S_IDLE;
                    cpu_hold_q <= 1'b0;
                    dmg_q      <= '0;
                    bus_own_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_hold = cpu_hold_q;
    assign dmg      = dmg_q;
    assign bus_own  = bus_own_q;
    assign own_id   = own_id_q;
    assign tmo      = tmo_q;

endmodule

// File: tb/tb_vm1_qbus_arb.sv
// Directed bench for vm1_qbus_arb: one fixed-priority and one round-robin
// instance (NCH=4, TMO=8) sharing clock and reset, separate request inputs.
module tb_vm1_qbus_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic       sync_f, sync_r;
    logic [3:0] dmr_f, sack_f, dmr_r, sack_r;
    logic       hold_f, hold_r, own_f, own_r, tmo_f, tmo_r;
    logic [3:0] dmg_f, dmg_r;
    logic [1:0] id_f, id_r;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vm1_qbus_arb #(.NCH(4), .TMO(8), .RR(0)) u_fix (
        .pin_clk(clk), .pin_dclo(rst), .cpu_sync(sync_f), .dmr(dmr_f),
        .sack(sack_f), .cpu_hold(hold_f), .dmg(dmg_f), .bus_own(own_f),
        .own_id(id_f), .tmo(tmo_f)
    );

    vm1_qbus_arb #(.NCH(4), .TMO(8), .RR(1)) u_rr (
        .pin_clk(clk), .pin_dclo(rst), .cpu_sync(sync_r), .dmr(dmr_r),
        .sack(sack_r), .cpu_hold(hold_r), .dmg(dmg_r), .bus_own(own_r),
        .own_id(id_r), .tmo(tmo_r)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        sync_f = 1'b0; sync_r = 1'b0;
        dmr_f = 4'd0; sack_f = 4'd0; dmr_r = 4'd0; sack_r = 4'd0;
        #2 rst = 1'b1;
        #1;
        chk("rst_hold", {hold_f, hold_r}, 32'd0);
        chk("rst_dmg", {dmg_f, dmg_r}, 32'd0);
        chk("rst_own", {own_f, own_r, tmo_f, tmo_r}, 32'd0);
        chk("rst_id", {id_f, id_r}, 32'd0);
        tick();
        #3 rst = 1'b0;

        // Test 1: fixed priority, dmr=0110 -> channel 1
        dmr_f = 4'b0110;
        tick();                                   // edge 0
        chk("t1_hold", hold_f, 32'd1);
        chk("t1_id", id_f, 32'd1);
        chk("t1_dmg0", dmg_f, 32'd0);
        tick();                                   // edge 1
        chk("t1_dmg1", dmg_f, 32'h2);
        tick(); tick();                           // edges 2,3
        chk("t1_dmg3", dmg_f, 32'h2);
        sack_f = 4'b0010;
        tick();                                   // edge 4
        chk("t1_sack_dmg", dmg_f, 32'd0);
        chk("t1_sack_own", own_f, 32'd1);
        for (int i = 5; i < 9; i++) tick();       // edges 5..8
        chk("t1_own8", own_f, 32'd1);
        sack_f = 4'd0;
        dmr_f = 4'd0;
        tick();                                   // edge 9
        chk("t1_rel_own", own_f, 32'd0);
        chk("t1_gap_hold", hold_f, 32'd1);
        tick();                                   // edge 10
        chk("t1_idle_hold", hold_f, 32'd0);

        // Test 2: CPU cycle in progress defers the grant
        sync_f = 1'b1;
        dmr_f = 4'b0100;
        tick();
        chk("t2_id", id_f, 32'd2);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_wait_dmg", dmg_f, 32'd0);
            chk("t2_wait_hold", hold_f, 32'd1);
        end
        sync_f = 1'b0;
        tick();
        chk("t2_dmg", dmg_f, 32'h4);

        // Test 6: stray sack ignored, then withdrawal in GRANT
        sack_f = 4'b0001;
        tick();
        chk("t6_stray_dmg", dmg_f, 32'h4);
        chk("t6_stray_own", own_f, 32'd0);
        sack_f = 4'd0;
        dmr_f = 4'd0;
        tick();
        chk("t6_wd_dmg", dmg_f, 32'd0);
        chk("t6_wd_hold", hold_f, 32'd1);
        chk("t6_wd_tmo", tmo_f, 32'd0);
        tick();
        chk("t6_idle_hold", hold_f, 32'd0);

        // Test 5: sack on the expiry edge wins over timeout
        dmr_f = 4'b1000;
        tick();
        tick();                                   // edge G, cnt=0
        chk("t5_dmg", dmg_f, 32'h8);
        for (int i = 1; i < 8; i++) tick();       // edges G+1..G+7
        chk("t5_pre_dmg", dmg_f, 32'h8);
        sack_f = 4'b1000;
        tick();                                   // edge G+8, expiry
        chk("t5_own", own_f, 32'd1);
        chk("t5_tmo", tmo_f, 32'd0);
        chk("t5_dmg0", dmg_f, 32'd0);
        sack_f = 4'd0;
        dmr_f = 4'd0;
        tick();
        tick();
        chk("t5_idle", {hold_f, own_f}, 32'd0);

        // Test 3: round-robin, all requesting, order 0,1,2,3,0
        dmr_r = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t3_id", id_r, 32'(k % 4));
            tick();
            chk("t3_dmg", dmg_r, 32'd1 << (k % 4));
            sack_r = 4'(32'd1 << (k % 4));
            tick();
            chk("t3_own", {own_r, dmg_r}, 32'h10);
            sack_r = 4'd0;
            tick();
            chk("t3_gap_dmg", {own_r, dmg_r}, 32'd0);
            tick();
            chk("t3_idle", {hold_r, dmg_r}, 32'd0);
        end

        // Test 4: timeout on channel 3 (pointer is 1), then channel 0 wins
        dmr_r = 4'b1000;
        tick();
        chk("t4_id", id_r, 32'd3);
        tick();                                   // edge G
        chk("t4_dmg", dmg_r, 32'h8);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("t4_dmg_hi", {tmo_r, dmg_r}, 32'h08);
        end
        dmr_r = 4'b1001;
        tick();                                   // edge G+8
        chk("t4_tmo", {tmo_r, dmg_r}, 32'h10);
        tick();
        chk("t4_tmo_pulse", tmo_r, 32'd0);
        chk("t4_gap_hold", hold_r, 32'd0);
        tick();
        chk("t4_next_id", id_r, 32'd0);
        tick();
        chk("t4_next_dmg", dmg_r, 32'h1);
        dmr_r = 4'd0;
        tick();
        tick();

        // Test 7: asynchronous reset during ownership
        dmr_r = 4'b0100;
        tick();
        chk("t7_id", id_r, 32'd2);
        tick();
        sack_r = 4'b0100;
        tick();
        chk("t7_own", own_r, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t7_rst_out", {hold_r, own_r, tmo_r, dmg_r}, 32'd0);
        chk("t7_rst_id", id_r, 32'd0);
        sack_r = 4'd0;
        dmr_r = 4'b1001;
        rst = 1'b0;
        tick();
        chk("t7_ptr0", id_r, 32'd0);
        chk("t7_hold", hold_r, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
